// File: rtl/fp_issue_sequencer.sv
// Decode-stage issue sequencer for F-class instructions: picks a fixed latency,
// stalls IF/ID while the FP ALU runs, and raises the done/write-back strobes.
module fp_issue_sequencer #(
    parameter int LAT_ADD = 3,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 16,
    parameter int LAT_FMA = 5,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fp_valid,
    input  logic [6:0]  opcode_f,
    input  logic [6:0]  func_7_f,
    input  logic [4:0]  rd_f,
    input  logic        flush_out,
    output logic        stall_out,
    output logic        fpu_start,
    output logic        flag_done,
    output logic        wb_en_f,
    output logic [4:0]  wb_rd_f,
    output logic        busy,
    output logic [15:0] fp_retired
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [6:0] OP_FP     = 7'b1010011;
    localparam logic [6:0] OP_FMADD  = 7'b1000011;
    localparam logic [6:0] OP_FMSUB  = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB = 7'b1001011;
    localparam logic [6:0] OP_FNMADD = 7'b1001111;

    localparam logic [6:0] F7_ADD  = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0000100;
    localparam logic [6:0] F7_MUL  = 7'b0001000;
    localparam logic [6:0] F7_DIV  = 7'b0001100;
    localparam logic [6:0] F7_SQRT = 7'b0101100;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] lat;
    logic [4:0]       rd_q;
    logic [4:0]       rd_nxt;
    logic             start_nxt;
    logic             accept;
    logic             retire;

    always_comb begin
        lat = CNT_W'(1);
        if (opcode_f == OP_FP) begin
            case (func_7_f)
                F7_ADD, F7_SUB:  lat = CNT_W'(LAT_ADD);
                F7_MUL:          lat = CNT_W'(LAT_MUL);
                F7_DIV, F7_SQRT: lat = CNT_W'(LAT_DIV);
                default:         lat = CNT_W'(1);
            endcase
        end else if (opcode_f == OP_FMADD || opcode_f == OP_FMSUB ||
                     opcode_f == OP_FNMSUB || opcode_f == OP_FNMADD) begin
            lat = CNT_W'(LAT_FMA);
        end
    end

    // A flush in the DONE cycle kills the result: no strobe, no retire count.
    assign accept = (state == IDLE) && fp_valid && !flush_out;
    assign retire = (state == DONE) && !flush_out;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_nxt    = rd_q;
        start_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                    cnt_nxt   = lat;
                    rd_nxt    = rd_f;
                    start_nxt = 1'b1;
                end
            end
            EXEC: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (flush_out) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_q       <= '0;
            fpu_start  <= 1'b0;
            fp_retired <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rd_q      <= rd_nxt;
            fpu_start <= start_nxt;
            if (retire) begin
                fp_retired <= fp_retired + 16'd1;
            end
        end
    end

    // Gated by rst so the stall drops immediately even while decode still holds fp_valid.
    assign stall_out = !rst && (accept || (state == EXEC));
    assign flag_done = retire;
    assign wb_en_f   = retire;
    assign wb_rd_f   = retire ? rd_q : 5'd0;
    assign busy      = (state != IDLE);

endmodule
